// File: rtl/store_queue_pkg.sv
// Shared definitions for the circular store queue: rename-tag layout, access
// size encodings, per-entry control bits and byte-enable helpers.
package sq_pkg;

    localparam int TAG_FU_ID  = 0;
    localparam int TAG_ISS_ID = 4;
    localparam int TAG_DEST   = 36;
    localparam int SQ_LANES   = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef struct packed {
        logic       valid;
        logic       addr_ok;
        logic       data_ok;
        logic [1:0] size;
        logic [3:0] be;
    } sq_ctrl_t;

    // The unused size encoding 3 is treated as a full word.
    function automatic logic [3:0] be_from_size(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] be_at_lane(input logic [1:0] size, input logic [1:0] lane);
        return be_from_size(size) << lane;
    endfunction

endpackage

// File: rtl/store_queue_if.sv
// Bundle of dispatch, CDB, branch, memory-drain, load-lookup and status signals
// between the store queue (slave) and its surroundings (master).
interface store_queue_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 41,
    parameter int DEPTH      = 16,
    parameter int BR_W       = 4
) ();

    logic                      push_valid;
    logic                      push_ready;
    logic [DATA_WIDTH-1:0]     push_base;
    logic                      push_base_tagged;
    logic [TAG_WIDTH-1:0]      push_base_tag;
    logic [11:0]               push_imm;
    logic [DATA_WIDTH-1:0]     push_data;
    logic                      push_data_tagged;
    logic [TAG_WIDTH-1:0]      push_data_tag;
    logic [1:0]                push_size;
    logic [BR_W-1:0]           push_br_mask;

    logic                      cdb_valid;
    logic [TAG_WIDTH-1:0]      cdb_tag;
    logic [DATA_WIDTH-1:0]     cdb_value;

    logic                      br_valid;
    logic [$clog2(BR_W)-1:0]   br_idx;
    logic                      br_mispredict;

    logic                      mem_valid;
    logic                      mem_ready;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [3:0]                mem_be;

    logic                      ld_valid;
    logic [ADDR_WIDTH-1:0]     ld_addr;
    logic [1:0]                ld_size;
    logic                      ld_hit;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      ld_stall;

    logic [$clog2(DEPTH):0]    count;
    logic                      empty;

    modport master (
        output push_valid, push_base, push_base_tagged, push_base_tag, push_imm,
               push_data, push_data_tagged, push_data_tag, push_size, push_br_mask,
               cdb_valid, cdb_tag, cdb_value, br_valid, br_idx, br_mispredict,
               mem_ready, ld_valid, ld_addr, ld_size,
        input  push_ready, mem_valid, mem_addr, mem_data, mem_be,
               ld_hit, ld_data, ld_stall, count, empty
    );

    modport slave (
        input  push_valid, push_base, push_base_tagged, push_base_tag, push_imm,
               push_data, push_data_tagged, push_data_tag, push_size, push_br_mask,
               cdb_valid, cdb_tag, cdb_value, br_valid, br_idx, br_mispredict,
               mem_ready, ld_valid, ld_addr, ld_size,
        output push_ready, mem_valid, mem_addr, mem_data, mem_be,
               ld_hit, ld_data, ld_stall, count, empty
    );

endinterface

// File: rtl/store_queue_fwd_select.sv
// Youngest-match priority selector: scans the circular queue from head towards
// tail so the last matching slot seen (closest to tail) wins.
module sq_fwd_select #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match_i,
    input  logic [IDX_W-1:0] head_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_i[IDX_W'(head_i + IDX_W'(k))]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(head_i + IDX_W'(k));
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: holds in-order stores until operands and covering
// branches resolve, drains them to memory and forwards to younger loads.
module store_queue
    import sq_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 41,
    parameter int DEPTH      = 16,
    parameter int BR_W       = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    store_queue_if.slave sq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    sq_ctrl_t              ctrl_q     [DEPTH];
    sq_ctrl_t              ctrl_d     [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q     [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d     [DEPTH];
    logic [11:0]           imm_q      [DEPTH];
    logic [11:0]           imm_d      [DEPTH];
    logic [TAG_WIDTH-1:0]  addr_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  addr_tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]  data_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  data_tag_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q     [DEPTH];
    logic [DATA_WIDTH-1:0] data_d     [DEPTH];
    logic [BR_W-1:0]       mask_q     [DEPTH];
    logic [BR_W-1:0]       mask_d     [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;

    logic [PTR_W-1:0]      count_w, flush_ptr, push_ptr;
    logic [IDX_W-1:0]      head_idx, push_idx, fwd_idx;
    logic                  br_correct, br_flush, flush_found;
    logic [DEPTH-1:0]      flush_hit, addr_cap, data_cap, fwd_match;
    logic                  mem_valid_w, mem_fire, push_fire, push_drop;
    logic                  p_base_ok, p_data_ok;
    logic [DATA_WIDTH-1:0] p_base, p_data;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [BR_W-1:0]       p_mask;
    logic [3:0]            ld_be;
    logic                  any_pending, fwd_found, fwd_cover;

    function automatic logic [DATA_WIDTH-1:0] lane_shift(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [1:0] lane);
        return d << {lane, 3'b000};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] eff_addr(input logic [DATA_WIDTH-1:0] base,
                                                       input logic [11:0] imm);
        return ADDR_WIDTH'(base + {{(DATA_WIDTH-12){imm[11]}}, imm});
    endfunction

    assign count_w     = tail_q - head_q;
    assign head_idx    = head_q[IDX_W-1:0];
    assign br_correct  = sq.br_valid && !sq.br_mispredict;
    assign br_flush    = sq.br_valid && sq.br_mispredict;
    assign mem_valid_w = ctrl_q[head_idx].valid && ctrl_q[head_idx].addr_ok &&
                         ctrl_q[head_idx].data_ok && (mask_q[head_idx] == '0);
    assign mem_fire    = mem_valid_w && sq.mem_ready;

    assign sq.push_ready = count_w < PTR_W'(DEPTH);
    assign sq.count      = count_w;
    assign sq.empty      = (count_w == '0);
    assign sq.mem_valid  = mem_valid_w;
    assign sq.mem_addr   = {addr_q[head_idx][ADDR_WIDTH-1:2], 2'b00};
    assign sq.mem_data   = data_q[head_idx];
    assign sq.mem_be     = ctrl_q[head_idx].be;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            flush_hit[i] = br_flush && ctrl_q[i].valid && mask_q[i][sq.br_idx];
            addr_cap[i]  = ctrl_q[i].valid && !ctrl_q[i].addr_ok && sq.cdb_valid &&
                           (sq.cdb_tag == addr_tag_q[i]);
            data_cap[i]  = ctrl_q[i].valid && !ctrl_q[i].data_ok && sq.cdb_valid &&
                           (sq.cdb_tag == data_tag_q[i]);
        end
    end

    // Flushed entries sit contiguously at the tail, so the oldest one is the rollback point.
    always_comb begin
        flush_found = 1'b0;
        flush_ptr   = tail_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (!flush_found && flush_hit[IDX_W'(head_q + PTR_W'(k))]) begin
                flush_found = 1'b1;
                flush_ptr   = head_q + PTR_W'(k);
            end
        end
    end

    assign push_ptr  = flush_found ? flush_ptr : tail_q;
    assign push_idx  = push_ptr[IDX_W-1:0];
    assign push_drop = br_flush && sq.push_br_mask[sq.br_idx];
    assign push_fire = sq.push_valid && sq.push_ready && !push_drop;

    // Operands arriving on the CDB in the push cycle are bypassed into the new entry.
    assign p_base_ok = !sq.push_base_tagged ||
                       (sq.cdb_valid && sq.cdb_tag == sq.push_base_tag);
    assign p_data_ok = !sq.push_data_tagged ||
                       (sq.cdb_valid && sq.cdb_tag == sq.push_data_tag);
    assign p_base    = sq.push_base_tagged ? sq.cdb_value : sq.push_base;
    assign p_data    = sq.push_data_tagged ? sq.cdb_value : sq.push_data;
    assign p_addr    = eff_addr(p_base, sq.push_imm);

    always_comb begin
        p_mask = sq.push_br_mask;
        if (br_correct) p_mask[sq.br_idx] = 1'b0;
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        imm_d      = imm_q;
        addr_tag_d = addr_tag_q;
        data_tag_d = data_tag_q;
        data_d     = data_q;
        mask_d     = mask_q;
        head_d     = head_q;
        tail_d     = push_ptr;
        // Data is held raw until the address is known, then stored lane-aligned.
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_cap[i]) begin
                addr_d[i]         = eff_addr(sq.cdb_value, imm_q[i]);
                ctrl_d[i].addr_ok = 1'b1;
                ctrl_d[i].be      = be_at_lane(ctrl_q[i].size, addr_d[i][1:0]);
                if (ctrl_q[i].data_ok) begin
                    data_d[i] = lane_shift(data_q[i], addr_d[i][1:0]);
                end else if (data_cap[i]) begin
                    data_d[i] = lane_shift(sq.cdb_value, addr_d[i][1:0]);
                end
            end else if (data_cap[i]) begin
                data_d[i] = ctrl_q[i].addr_ok ? lane_shift(sq.cdb_value, addr_q[i][1:0])
                                              : sq.cdb_value;
            end
            if (data_cap[i]) ctrl_d[i].data_ok = 1'b1;
            if (br_correct) mask_d[i][sq.br_idx] = 1'b0;
            if (flush_hit[i]) ctrl_d[i].valid = 1'b0;
        end
        if (mem_fire) begin
            ctrl_d[head_idx].valid = 1'b0;
            head_d                 = head_q + PTR_W'(1);
        end
        if (push_fire) begin
            ctrl_d[push_idx].valid   = 1'b1;
            ctrl_d[push_idx].addr_ok = p_base_ok;
            ctrl_d[push_idx].data_ok = p_data_ok;
            ctrl_d[push_idx].size    = sq.push_size;
            ctrl_d[push_idx].be      = p_base_ok ? be_at_lane(sq.push_size, p_addr[1:0]) : 4'b0000;
            addr_d[push_idx]         = p_addr;
            imm_d[push_idx]          = sq.push_imm;
            addr_tag_d[push_idx]     = sq.push_base_tag;
            data_tag_d[push_idx]     = sq.push_data_tag;
            data_d[push_idx]         = p_base_ok ? lane_shift(p_data, p_addr[1:0]) : p_data;
            mask_d[push_idx]         = p_mask;
            tail_d                   = push_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i]     <= '0;
                addr_q[i]     <= '0;
                imm_q[i]      <= '0;
                addr_tag_q[i] <= '0;
                data_tag_q[i] <= '0;
                data_q[i]     <= '0;
                mask_q[i]     <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            imm_q      <= imm_d;
            addr_tag_q <= addr_tag_d;
            data_tag_q <= data_tag_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
        end
    end

    // Every queued store is older than the probing load.
    always_comb begin
        ld_be       = be_at_lane(sq.ld_size, sq.ld_addr[1:0]);
        any_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ctrl_q[i].valid && !ctrl_q[i].addr_ok) any_pending = 1'b1;
            fwd_match[i] = ctrl_q[i].valid && ctrl_q[i].addr_ok &&
                           (addr_q[i][ADDR_WIDTH-1:2] == sq.ld_addr[ADDR_WIDTH-1:2]) &&
                           ((ctrl_q[i].be & ld_be) != 4'b0000);
        end
    end

    sq_fwd_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fwd_select (
        .match_i (fwd_match),
        .head_i  (head_idx),
        .found_o (fwd_found),
        .idx_o   (fwd_idx)
    );

    assign fwd_cover   = ((ctrl_q[fwd_idx].be & ld_be) == ld_be) && ctrl_q[fwd_idx].data_ok;
    assign sq.ld_hit   = sq.ld_valid && !any_pending && fwd_found && fwd_cover;
    assign sq.ld_stall = sq.ld_valid && (any_pending || (fwd_found && !fwd_cover));
    assign sq.ld_data  = sq.ld_hit ? data_q[fwd_idx] : '0;

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised circular store queue that succeeds the fixed-depth shifting store buffer.
- Holds in-order issued stores until their address and data operands resolve from the CDB and every covering branch resolves correct. Then drains them one per cycle to data memory over a valid/ready port.
- Adds the following, which the shifting buffer lacks:
  - multi-level branch masks with selective flush;
  - byte-enable sizes (SB/SH/SW);
  - store-to-load forwarding with load-stall reporting.

Parameters:
- ADDR_WIDTH, 15, byte address width.
- DATA_WIDTH, 32, store data width. Fixed 4 byte lanes.
- TAG_WIDTH, 41, rename tag width: {dest[4:0], iss_id[31:0], fu_id[3:0]}.
- DEPTH, 16, entries. Power of two, ≥2.
- BR_W, 4, maximum number of unresolved branches in flight (mask bits).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- push_valid  in  1  new store from dispatch.
- push_ready  out  1  queue can accept a store.
- push_base  in  DATA_WIDTH  rs1 value (valid when !push_base_tagged).
- push_base_tagged  in  1  rs1 pending.
- push_base_tag  in  TAG_WIDTH  rs1 producer tag.
- push_imm  in  12  signed offset.
- push_data  in  DATA_WIDTH  rs2 value.
- push_data_tagged  in  1  rs2 pending.
- push_data_tag  in  TAG_WIDTH  rs2 producer tag.
- push_size  in  2  0=byte, 1=half, 2=word.
- push_br_mask  in  BR_W  branches this store depends on.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_value  in  DATA_WIDTH  broadcast value.
- br_valid  in  1  branch resolved.
- br_idx  in  clog2(BR_W)  mask bit resolved.
- br_mispredict  in  1  1 = flush dependents.
- mem_valid  out  1  drain request.
- mem_ready  in  1  memory accepts.
- mem_addr  out  ADDR_WIDTH  word-aligned address.
- mem_data  out  DATA_WIDTH  lane-aligned data.
- mem_be  out  4  byte enables.
- ld_valid  in  1  load lookup.
- ld_addr  in  ADDR_WIDTH  load byte address.
- ld_size  in  2  load size.
- ld_hit  out  1  forward data valid.
- ld_data  out  DATA_WIDTH  forwarded lane-aligned word.
- ld_stall  out  1  load must retry.
- count  out  clog2(DEPTH)+1  occupancy.
- empty  out  1  count==0.

Behaviour:
- Reset (asynchronous, reset=0):
  - head=tail=0, with one wrap bit each.
  - All entries invalid.
  - mem_valid=0, ld_hit=0, ld_stall=0, count=0, empty=1, push_ready=1.
- Entry fields: valid, addr_ok, addr/base, addr_tag, imm, data_ok, data, data_tag, size, be, br_mask.
- Push:
  - push_ready = (count<DEPTH). It does not depend on a drain in the same cycle.
  - Push is accepted when push_valid&&push_ready. It writes entry[tail] and advances tail with wrap.
- Address:
  - Once base is known: addr = base + sext(imm), truncated to ADDR_WIDTH.
  - be = size-mask << addr[1:0].
  - Data is stored lane-shifted: data << 8*addr[1:0], truncated. While the address is pending, data is held raw and shifted when the address resolves.
- CDB capture:
  - Every entry with a pending operand whose tag equals cdb_tag captures it in the same cycle.
  - If a push and a matching CDB occur in the same cycle, the pushed entry captures the value (bypass) and is never left waiting.
- Branch resolve, correct (br_valid && !br_mispredict):
  - Clear bit br_idx in all masks, including the entry being pushed.
- Branch resolve, mispredict (br_valid && br_mispredict):
  - Invalidate every entry whose br_idx bit is set.
  - Invariant: these entries are contiguous at the tail. tail rolls back to the oldest such entry in the same edge.
  - A push in the same cycle whose push_br_mask has br_idx set is dropped.
- Drain:
  - mem_valid = head valid && addr_ok && data_ok && br_mask==0.
  - mem_addr/data/be come from the head entry and are held stable until mem_ready.
  - On mem_valid&&mem_ready, the head entry is freed and head advances.
  - Push and drain in the same cycle: count unchanged.
- Forwarding (combinational; all queue entries are older than the load):
  - ld_stall=1 if any valid entry has !addr_ok.
  - Otherwise select the youngest valid entry with the same word address and overlapping be.
  - If it fully covers the load's be and data_ok: ld_hit=1, ld_data=entry data.
  - Otherwise (partial cover or data pending): ld_stall=1.
  - No overlap: ld_hit=0, ld_stall=0.
  - All outputs are 0 when !ld_valid.
- Boundary conditions:
  - Full: push ignored.
  - Empty: mem_valid=0.
  - Pointer wrap-around uses the wrap bit for full/empty.
  - Reset mid-drain: request dropped immediately.
  - Mispredict while the head is requesting: the head has br_mask==0, so it is unaffected.

Decomposition:
- Package sq_pkg:
  - tag field offsets (TAG_DEST, TAG_ISS_ID, TAG_FU_ID);
  - size encodings;
  - entry struct/typedef;
  - be-from-size function.
- One sub-module, sq_fwd_select: a youngest-match priority selector over DEPTH entries, ordered relative to head.

Test Plan:
- Push SW base=0x100 imm=4 data=0xDEADBEEF, all ready, mem_ready=1 → next cycle mem_valid, addr=0x104, be=4'b1111. After the handshake, empty=1.
- Push SB addr tag T, data=0xAB; CDB T=0x201 two cycles later → addr=0x201, be=4'b0010, mem_data=0x0000AB00.
- Push 3 stores with mask bit1, then br_valid idx=1 mispredict → count drops by 3, tail rolls back, none drained.
- Two SWs to 0x40 (0x11111111 then 0x22222222), then load LW 0x40 → ld_hit=1, ld_data=0x22222222. Load LW 0x44 → ld_hit=0, ld_stall=0.
- SB to 0x41, then load LW 0x40 → ld_stall=1. Store with unresolved address pending → any load gives ld_stall=1.
- Fill DEPTH=16 → push_ready=0. Drain and push in the same cycle 20 times across the wrap → FIFO order preserved. Assert reset mid-stream → all outputs at reset values asynchronously.
